// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types, default sizes and index-width helper for the UART TX arbiter
package uart_arb_pkg;

   typedef enum logic {IDLE, LOCK} state_t;

   localparam int NUM_REQ_D = 4;
   localparam int DBIT_D    = 8;
   localparam int TIMEOUT_D = 1024;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first set request after rr_ptr with wrap
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N = NUM_REQ_D,
   parameter int W = idx_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] rr_ptr,
   output logic         any_req,
   output logic [W-1:0] winner
);

   logic [W-1:0] idx;

   // scan from farthest to nearest so the nearest set request after rr_ptr wins
   always_comb begin
      any_req = |req;
      winner  = '0;
      idx     = '0;
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(rr_ptr) + k) % N);
         if (req[idx]) winner = idx;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART TX FIFO with stall watchdog
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_D,
   parameter int DBIT    = DBIT_D,
   parameter int TIMEOUT = TIMEOUT_D
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DBIT-1:0]    req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       wr_uart,
   output logic [DBIT-1:0]            w_data,
   input  logic                       tx_full,
   output logic [idx_w(NUM_REQ)-1:0]  grant_id,
   output logic                       busy,
   output logic                       abort_err
);

   localparam int GW = idx_w(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT) + 1;

   state_t        state, state_nx;
   logic [GW-1:0] rr_ptr, rr_ptr_nx, grant_nx, winner;
   logic [CW-1:0] wd_cnt, wd_nx;
   logic          any_req, starve, done;

   uart_rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
      .req     (req_valid),
      .rr_ptr  (rr_ptr),
      .any_req (any_req),
      .winner  (winner)
   );

   // state, owner, fairness pointer and watchdog registers; reset drops any grant at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= GW'(NUM_REQ - 1);
         wd_cnt   <= '0;
      end else begin
         state    <= state_nx;
         grant_id <= grant_nx;
         rr_ptr   <= rr_ptr_nx;
         wd_cnt   <= wd_nx;
      end
   end

   // arbitrate in IDLE; in LOCK pass the owner's bytes straight through and watch for stalls
   always_comb begin
      state_nx  = state;
      grant_nx  = grant_id;
      rr_ptr_nx = rr_ptr;
      wd_nx     = '0;
      req_ready = '0;
      wr_uart   = 1'b0;
      w_data    = '0;
      abort_err = 1'b0;
      starve    = 1'b0;
      done      = 1'b0;
      busy      = (state == LOCK);
      if (state == IDLE) begin
         if (any_req) begin
            state_nx = LOCK;
            grant_nx = winner;
         end
      end else begin
         req_ready[grant_id] = !tx_full;
         wr_uart   = req_valid[grant_id] & !tx_full;
         w_data    = wr_uart ? req_data[grant_id*DBIT +: DBIT] : '0;
         starve    = !req_valid[grant_id] & !tx_full;
         abort_err = starve & (wd_cnt == CW'(TIMEOUT - 1));
         wd_nx     = (starve & !abort_err) ? wd_cnt + 1'b1 : '0;
         done      = (wr_uart & req_last[grant_id]) | abort_err;
         if (done) begin
            state_nx  = IDLE;
            rr_ptr_nx = grant_id;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with directed scenarios and randomized traffic
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int TO = 16;
   localparam int GW = 2;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DB-1:0] req_data = '0;
   logic [N-1:0]    req_last = '0;
   logic [N-1:0]    req_ready;
   logic            wr_uart;
   logic [DB-1:0]   w_data;
   logic            tx_full = 1'b0;
   logic [GW-1:0]   grant_id;
   logic            busy;
   logic            abort_err;

   uart_tx_arbiter #(.NUM_REQ(N), .DBIT(DB), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .wr_uart   (wr_uart),
      .w_data    (w_data),
      .tx_full   (tx_full),
      .grant_id  (grant_id),
      .busy      (busy),
      .abort_err (abort_err)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   logic [DB:0] src   [N][$];
   logic [DB:0] exp_q [N][$];
   int          grants[$];
   int          n_wr = 0;
   int          n_abort = 0;

   logic [N-1:0] en = '1;
   logic         full_v = 1'b0;
   logic         rst_v = 1'b1;

   int           owner = 0;
   int           last_owner = N - 1;
   int           streak = 0;
   logic         prev_busy = 1'b0;
   logic         prev_end = 1'b0;
   logic [N-1:0] prev_valid = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0h, required %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // next owner under packet round-robin: first valid requester after the previous owner
   function automatic int pick(input logic [N-1:0] v, input int from);
      for (int k = 1; k <= N; k++)
         if (v[(from + k) % N]) return (from + k) % N;
      return -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < N; i++)
         if (src[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic send_byte(input int i, input logic [DB-1:0] d, input logic l);
      src[i].push_back({l, d});
      exp_q[i].push_back({l, d});
   endtask

   task automatic send(input int i, input int n, input logic lastf);
      for (int b = 0; b < n; b++) send_byte(i, DB'($urandom), lastf && (b == n - 1));
   endtask

   // one clock of stimulus: drive at the falling edge, retire accepted bytes before the rising edge
   task automatic cycle();
      logic [DB:0] h;
      @(negedge clk);
      reset_n = !rst_v;
      for (int i = 0; i < N; i++) begin
         h = (src[i].size() > 0) ? src[i][0] : '0;
         req_valid[i] = en[i] && (src[i].size() > 0);
         req_last[i] = h[DB];
         req_data[i*DB +: DB] = h[DB-1:0];
      end
      tx_full = full_v;
      #4;
      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_ready[i]) void'(src[i].pop_front());
      if (rst_v)
         for (int i = 0; i < N; i++) src[i].delete();
   endtask

   task automatic do_reset();
      rst_v = 1'b1;
      repeat (2) cycle();
      rst_v = 1'b0;
      grants.delete();
      n_wr = 0;
      n_abort = 0;
   endtask

   task automatic wait_src(input int i, input int sz);
      int c = 0;
      while (src[i].size() != sz && c < 100) begin
         cycle();
         c++;
      end
      chk("wait_src_timeout", src[i].size(), sz);
   endtask

   task automatic drain(input int max);
      int c = 0;
      bit ok = 1'b0;
      while (!ok && c < max) begin
         cycle();
         c++;
         ok = all_empty() && !busy;
      end
      chk("drain_timeout", ok, 1);
      c = 0;
      for (int i = 0; i < N; i++) c += exp_q[i].size();
      chk("bytes_outstanding", c, 0);
   endtask

   task automatic chk_grants(input string nm, input int n, input int g0 = 0, input int g1 = 0,
                             input int g2 = 0, input int g3 = 0);
      int e[4];
      e = '{g0, g1, g2, g3};
      chk({nm, "_count"}, grants.size(), n);
      for (int k = 0; k < n && k < grants.size(); k++) chk(nm, grants[k], e[k]);
   endtask

   // monitor: compares every cycle's outputs against the packet-level model and byte scoreboard
   initial begin
      logic [DB:0]  e;
      logic [N-1:0] er;
      bit           end_now, starving;
      forever begin
         @(negedge clk);
         #3;
         if (!reset_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_wr", wr_uart, 0);
            chk("rst_abort", abort_err, 0);
            chk("rst_wdata", w_data, 0);
            chk("rst_grant", grant_id, 0);
            for (int i = 0; i < N; i++) exp_q[i].delete();
            last_owner = N - 1;
            streak = 0;
            prev_busy = 1'b0;
            prev_end = 1'b0;
            prev_valid = '0;
         end else begin
            end_now = 1'b0;
            if (!prev_busy) begin
               chk("arb_latency", busy, |prev_valid);
               if (busy) begin
                  owner = pick(prev_valid, last_owner);
                  chk("grant_rr", grant_id, owner);
                  grants.push_back(int'(grant_id));
               end
            end else begin
               chk("busy_hold", busy, !prev_end);
               if (busy) chk("grant_kept", grant_id, owner);
            end
            if (busy) begin
               er = tx_full ? '0 : N'(1 << owner);
               chk("ready", req_ready, er);
               chk("wr", wr_uart, req_valid[owner] && !tx_full);
            end else begin
               chk("ready_idle", req_ready, 0);
               chk("wr_idle", wr_uart, 0);
            end
            if (wr_uart) begin
               n_wr++;
               chk("byte_expected", exp_q[owner].size() > 0, 1);
               if (exp_q[owner].size() > 0) begin
                  e = exp_q[owner].pop_front();
                  chk("w_data", w_data, e[DB-1:0]);
                  if (e[DB]) begin
                     end_now = 1'b1;
                     last_owner = owner;
                  end
               end
            end else begin
               chk("w_data_zero", w_data, 0);
            end
            starving = busy && !req_valid[owner] && !tx_full;
            streak = starving ? streak + 1 : 0;
            chk("abort", abort_err, starving && streak == TO);
            if (abort_err) n_abort++;
            if (starving && streak == TO) begin
               end_now = 1'b1;
               last_owner = owner;
               streak = 0;
            end
            prev_busy = busy;
            prev_valid = req_valid;
            prev_end = end_now;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete at %0t", $time);
      $fatal(1);
   end

   initial begin
      int sent;
      repeat (3) cycle();
      rst_v = 1'b0;
      grants.delete();
      n_wr = 0;

      send_byte(0, 8'h41, 1'b0);
      send_byte(0, 8'h42, 1'b0);
      send_byte(0, 8'h43, 1'b1);
      drain(100);
      chk("single_writes", n_wr, 3);
      chk_grants("single_grant", 1, 0);

      do_reset();
      for (int i = 0; i < N; i++) send(i, 2, 1'b1);
      drain(200);
      chk("rr_writes", n_wr, 8);
      chk_grants("rr_order", 4, 0, 1, 2, 3);

      do_reset();
      send(2, 4, 1'b1);
      wait_src(2, 2);
      full_v = 1'b1;
      repeat (5) cycle();
      full_v = 1'b0;
      drain(100);
      chk("bp_writes", n_wr, 4);
      chk("bp_aborts", n_abort, 0);
      chk_grants("bp_grant", 1, 2);

      do_reset();
      send(1, 1, 1'b0);
      send(2, 2, 1'b1);
      drain(200);
      chk("wd_aborts", n_abort, 1);
      chk("wd_writes", n_wr, 3);
      chk_grants("wd_order", 2, 1, 2);

      do_reset();
      send(0, 2, 1'b1);
      send(0, 2, 1'b1);
      send(3, 2, 1'b1);
      drain(200);
      chk("fair_writes", n_wr, 6);
      chk_grants("fair_order", 3, 0, 3, 0);

      do_reset();
      send(1, 3, 1'b1);
      wait_src(1, 2);
      do_reset();
      send(1, 2, 1'b1);
      send(0, 2, 1'b1);
      drain(200);
      chk("rstmid_writes", n_wr, 4);
      chk_grants("rstmid_order", 2, 0, 1);

      do_reset();
      sent = 0;
      repeat (3000) begin
         for (int i = 0; i < N; i++) begin
            if (src[i].size() < 3 && $urandom_range(0, 3) == 0) begin
               int n = $urandom_range(1, 4);
               send(i, n, 1'b1);
               sent += n;
            end
            en[i] = ($urandom_range(0, 3) != 0);
         end
         full_v = ($urandom_range(0, 4) == 0);
         cycle();
      end
      en = '1;
      full_v = 1'b0;
      drain(1000);
      chk("rand_writes", n_wr, sent);
      chk("rand_aborts", n_abort, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
